// File: rtl/ir_receiver_if.sv
// Bus-side signals of ir_receiver: register address, write strobe and interrupt handshake.
interface ir_receiver_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       IRQ_RAISE;
    logic       IRQ_ACK;

    modport master (output BUS_ADDR, output BUS_WE, output IRQ_ACK, input IRQ_RAISE);
    modport slave  (input BUS_ADDR, input BUS_WE, input IRQ_ACK, output IRQ_RAISE);
endinterface

// File: rtl/ir_receiver.sv
// ir_receiver: decodes {car, command} packets from a demodulated IR envelope onto the shared bus.
// Define IR_RX_GLITCH_FILTER_EN to add a GlitchCount-cycle stability filter ahead of edge detection.
module ir_receiver #(
    parameter logic [7:0] BASE_ADDR          = 8'hA0,
    parameter logic [3:0] CarId              = 4'b0010,
    parameter int         StartBurstSize     = 88,
    parameter int         GapSize            = 40,
    parameter int         CarSelectBurstSize = 22,
    parameter int         AssertBurstSize    = 44,
    parameter int         DeAssertBurstSize  = 22,
    parameter int         FrequencyCount     = 2500,
    parameter int         Tol                = 3,
    parameter int         GlitchCount        = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IR_RX,
    inout  wire  [7:0]  BUS_DATA,
    ir_receiver_if.slave bus
);
    localparam logic [7:0] StatusAddr = BASE_ADDR + 8'd1;
    localparam int MaxA = (StartBurstSize > CarSelectBurstSize) ? StartBurstSize : CarSelectBurstSize;
    localparam int MaxB = (AssertBurstSize > DeAssertBurstSize) ? AssertBurstSize : DeAssertBurstSize;
    localparam int MaxMark = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int PrescaleWidth = (FrequencyCount > 1) ? $clog2(FrequencyCount) : 1;

    if (GlitchCount < 1 || FrequencyCount < 1) begin : g_param_check
        $error("ir_receiver: GlitchCount and FrequencyCount must be positive");
    end

    typedef enum logic [1:0] {IDLE, MARK, SPACE, WAIT_REL} state_t;

    logic                     sync1, sync2, line, env, env_prev, fall, rise, tick;
    logic [PrescaleWidth-1:0] prescale;
    logic [7:0]               len;
    state_t                   state;
    logic [2:0]               field;
    logic [2:0]               command;
    logic [7:0]               data, rd_data;
    logic                     valid, overrun, frame_err, irq, rd_drive;
    logic                     match_start, match_select, match_one, match_zero;
    logic                     data_rd, status_rd, status_wr;

    function automatic logic near(input logic [7:0] l, input int e);
        int v;
        v = int'(l);
        return (v >= e - Tol) && (v <= e + Tol);
    endfunction

`ifdef IR_RX_GLITCH_FILTER_EN
    localparam int GlitchWidth = $clog2(GlitchCount + 1);
    logic                   filtered;
    logic [GlitchWidth-1:0] stable_cnt;

    // The filtered line only follows sync2 once it has disagreed for GlitchCount cycles in a row.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            filtered   <= 1'b1;
            stable_cnt <= '0;
        end else if (sync2 == filtered) begin
            stable_cnt <= '0;
        end else if (stable_cnt == GlitchWidth'(GlitchCount - 1)) begin
            filtered   <= sync2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
    assign line = filtered;
`else
    assign line = sync2;
`endif

    // Idle line is high, so the synchroniser resets to 1 to avoid a false mark after reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            env      <= 1'b0;
            env_prev <= 1'b0;
        end else begin
            sync1    <= IR_RX;
            sync2    <= sync1;
            env      <= ~line;
            env_prev <= env;
        end
    end

    assign fall = env & ~env_prev;
    assign rise = ~env & env_prev;
    assign tick = (prescale == PrescaleWidth'(FrequencyCount - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prescale <= '0;
            len      <= '0;
        end else if (fall | rise) begin
            prescale <= '0;
            len      <= '0;
        end else if (tick) begin
            prescale <= '0;
            if (len != 8'hFF) len <= len + 8'd1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    assign match_start  = near(len, StartBurstSize);
    assign match_select = near(len, CarSelectBurstSize);
    assign match_one    = near(len, AssertBurstSize);
    assign match_zero   = near(len, DeAssertBurstSize);

    assign data_rd   = !bus.BUS_WE && (bus.BUS_ADDR == BASE_ADDR);
    assign status_rd = !bus.BUS_WE && (bus.BUS_ADDR == StatusAddr);
    assign status_wr = bus.BUS_WE && (bus.BUS_ADDR == StatusAddr);

    // Bus side effects are written first so that frame errors and commits later in the block win ties.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            field     <= '0;
            command   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
            rd_drive  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_drive <= 1'b0;
            if (data_rd) begin
                rd_drive <= 1'b1;
                rd_data  <= data;
                valid    <= 1'b0;
                overrun  <= 1'b0;
            end else if (status_rd) begin
                rd_drive <= 1'b1;
                rd_data  <= {valid, overrun, frame_err, 5'b0};
            end
            if (status_wr) frame_err <= 1'b0;
            if (bus.IRQ_ACK) irq <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= MARK;
                        field <= 3'd0;
                    end
                end
                MARK: begin
                    if (rise) begin
                        if (field == 3'd0) begin
                            if (match_start) begin
                                field <= 3'd1;
                                state <= SPACE;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (field == 3'd1) begin
                            if (match_select) begin
                                field <= 3'd2;
                                state <= SPACE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end else if (match_one || match_zero) begin
                            // Command bits arrive LSB first, so shift them in from the top.
                            if (field == 3'd5) begin
                                data  <= {CarId, match_one, command};
                                valid <= 1'b1;
                                irq   <= 1'b1;
                                if (data_rd) overrun <= overrun;
                                else if (valid) overrun <= 1'b1;
                                state <= IDLE;
                            end else begin
                                command <= {match_one, command[2:1]};
                                field   <= field + 3'd1;
                                state   <= SPACE;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (int'(len) > MaxMark + Tol) begin
                        if (field != 3'd0) frame_err <= 1'b1;
                        state <= WAIT_REL;
                    end
                end
                SPACE: begin
                    if (int'(len) > GapSize + Tol) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (fall) begin
                        if (int'(len) < GapSize - Tol) begin
                            frame_err <= 1'b1;
                            field     <= 3'd0;
                        end
                        state <= MARK;
                    end
                end
                WAIT_REL: begin
                    if (rise) state <= IDLE;
                end
            endcase
        end
    end

    assign bus.IRQ_RAISE = irq;
    assign BUS_DATA      = rd_drive ? rd_data : 8'hzz;
endmodule
